// File: rtl/sram_arbiter_if.sv
// Bus bundle between sram_arbiter and its surroundings: CPU port, debug/loader port,
// SRAM strobes and address, and arbiter status. The SRAM data bus is a separate inout.
interface sram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;

  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_wdata;
  logic [15:0] dbg_rdata;
  logic        dbg_ack;

  logic        CE;
  logic        UB;
  logic        LB;
  logic        OE;
  logic        WE;
  logic [19:0] ADDR;

  logic        busy;
  logic        grant;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    output CE, UB, LB, OE, WE, ADDR,
    output busy, grant
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    input  CE, UB, LB, OE, WE, ADDR,
    input  busy, grant
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (CPU / debug loader) round-robin arbiter for an asynchronous 16-bit SRAM.
// Each transfer runs IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> DONE with registered strobes.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  sram_arbiter_if.slave bus,
  inout  wire  [15:0]   Data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_ACCESS = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        ptr_dbg;   // owner of the previous transfer, used to break ties
  logic        op_we;
  logic [15:0] op_wdata;
  logic        drive;
  logic        pick_dbg;

  // Debug wins when it is the only requester, or on a tie when the CPU went last.
  assign pick_dbg = bus.dbg_req & (~bus.cpu_req | ~ptr_dbg);

  assign Data = drive ? op_wdata : 16'hzzzz;

  // NOTE: every register here is assigned with <= so all of them see pre-edge values;
  // blocking assignments would let later statements observe this cycle's updates.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr_dbg       <= 1'b1;
      op_we         <= 1'b0;
      op_wdata      <= '0;
      drive         <= 1'b0;
      bus.CE        <= 1'b1;
      bus.UB        <= 1'b1;
      bus.LB        <= 1'b1;
      bus.OE        <= 1'b1;
      bus.WE        <= 1'b1;
      bus.ADDR      <= '0;
      bus.busy      <= 1'b0;
      bus.grant     <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dbg_req) begin
            state     <= SETUP;
            bus.busy  <= 1'b1;
            ptr_dbg   <= pick_dbg;
            bus.grant <= pick_dbg;
            op_we     <= pick_dbg ? bus.dbg_we    : bus.cpu_we;
            op_wdata  <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            bus.ADDR  <= {4'h0, (pick_dbg ? bus.dbg_addr : bus.cpu_addr)};
            bus.CE    <= 1'b0;
            bus.UB    <= 1'b0;
            bus.LB    <= 1'b0;
            bus.OE    <= pick_dbg ? bus.dbg_we : bus.cpu_we;
            bus.WE    <= 1'b1;
          end
        end

        SETUP: begin
          state  <= ACCESS;
          cnt    <= '0;
          bus.WE <= ~op_we;
          drive  <= op_we;
        end

        ACCESS: begin
          if (cnt == LAST_ACCESS) begin
            state  <= DONE;
            bus.CE <= 1'b1;
            bus.UB <= 1'b1;
            bus.LB <= 1'b1;
            bus.OE <= 1'b1;
            bus.WE <= 1'b1;
            drive  <= 1'b0;
            // Read data is sampled here, while OE is still low on the SRAM.
            if (!op_we) begin
              if (bus.grant) bus.dbg_rdata <= Data;
              else           bus.cpu_rdata <= Data;
            end
            if (bus.grant) bus.dbg_ack <= 1'b1;
            else           bus.cpu_ack <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.cpu_ack <= 1'b0;
          bus.dbg_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level model and an SRAM device model.
module tb_sram_arbiter;
  localparam int W = 2;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  wire  [15:0] sram_data;

  sram_arbiter_if bus();

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus),
    .Data  (sram_data)
  );

  always #10 Clk = ~Clk;

  // ---------------- SRAM device model ----------------
  logic [15:0] sram_mem [0:65535];

  function automatic logic [15:0] fill(input int a);
    return 16'(a) ^ 16'hA5C3;
  endfunction

  assign sram_data = (!bus.CE && !bus.OE && bus.WE) ? sram_mem[bus.ADDR[15:0]] : 16'hzzzz;

  initial begin
    for (int i = 0; i < 65536; i++) sram_mem[i] = fill(i);
    forever begin
      @(negedge Clk);
      if (!bus.CE && !bus.WE) sram_mem[bus.ADDR[15:0]] = sram_data;
    end
  end

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          act = 1'b0;
  int          t_start = 0;
  bit          t_port, t_we;
  logic [15:0] t_addr, t_wdata;
  bit          last_dbg = 1'b1;
  bit          grant_exp = 1'b0;
  logic [19:0] addr_exp = '0;
  logic [15:0] rdata_exp [2];
  logic [15:0] ref_mem [0:65535];

  int n_cpu, n_dbg, n_acks, order, k_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Applies the effect of the edge ending the current cycle, from the inputs driven in it.
  task automatic model_advance();
    int p = cyc - t_start;
    if (act && t_we && p == 2) ref_mem[t_addr] = t_wdata;
    if (Reset) begin
      act = 1'b0; last_dbg = 1'b1; grant_exp = 1'b0; addr_exp = '0;
      rdata_exp[0] = '0; rdata_exp[1] = '0;
    end else if (act) begin
      if (p == W + 1 && !t_we) rdata_exp[t_port] = ref_mem[t_addr];
      if (p == W + 2) act = 1'b0;
    end else if (bus.cpu_req || bus.dbg_req) begin
      t_port    = (bus.cpu_req && bus.dbg_req) ? !last_dbg : bus.dbg_req;
      t_we      = t_port ? bus.dbg_we    : bus.cpu_we;
      t_addr    = t_port ? bus.dbg_addr  : bus.cpu_addr;
      t_wdata   = t_port ? bus.dbg_wdata : bus.cpu_wdata;
      act       = 1'b1;
      t_start   = cyc;
      last_dbg  = t_port;
      grant_exp = t_port;
      addr_exp  = {4'h0, t_addr};
    end
  endtask

  task automatic check_cycle();
    int p = cyc - t_start;
    bit strobe = act && p <= W + 1;
    bit acc = act && p >= 2 && p <= W + 1;
    chk("busy",      32'(bus.busy),      32'(act));
    chk("grant",     32'(bus.grant),     32'(grant_exp));
    chk("CE",        32'(bus.CE),        32'(!strobe));
    chk("UB",        32'(bus.UB),        32'(!strobe));
    chk("LB",        32'(bus.LB),        32'(!strobe));
    chk("OE",        32'(bus.OE),        32'(!(strobe && !t_we)));
    chk("WE",        32'(bus.WE),        32'(!(acc && t_we)));
    chk("ADDR",      32'(bus.ADDR),      32'(addr_exp));
    chk("cpu_ack",   32'(bus.cpu_ack),   32'(act && p == W + 2 && !t_port));
    chk("dbg_ack",   32'(bus.dbg_ack),   32'(act && p == W + 2 && t_port));
    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(rdata_exp[0]));
    chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(rdata_exp[1]));
    if (acc && t_we) chk("Data", 32'(sram_data), 32'(t_wdata));
  endtask

  task automatic tick();
    model_advance();
    @(posedge Clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dbg(input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return 16'h0070 + 16'($urandom_range(0, 15));
    return 16'($urandom);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = fill(i);
    rdata_exp[0] = '0;
    rdata_exp[1] = '0;
    set_cpu(0, 0, 0, 0);
    set_dbg(0, 0, 0, 0);

    // Reset for one cycle, then ten idle cycles at reset values.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("idle_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // CPU write 0x0074 <- 1234.
    set_cpu(1, 1, 16'h0074, 16'h1234);
    tick(); chk("wr_addr_c1", 32'(bus.ADDR), 32'h00074);
    tick(); chk("wr_we_c2", 32'(bus.WE), 32'h0); chk("wr_data_c2", 32'(sram_data), 32'h1234);
    tick(); chk("wr_we_c3", 32'(bus.WE), 32'h0); chk("wr_addr_c3", 32'(bus.ADDR), 32'h00074);
    tick(); chk("wr_ack_c4", 32'(bus.cpu_ack), 32'h1);
    set_cpu(0, 0, 0, 0);
    tick(); chk("wr_ack_c5", 32'(bus.cpu_ack), 32'h0);

    // CPU read 0x0074 returns 1234; debug rdata untouched.
    set_cpu(1, 0, 16'h0074, 16'h0);
    tick(); chk("rd_oe_c1", 32'(bus.OE), 32'h0);
    tick(); tick(); chk("rd_we_c3", 32'(bus.WE), 32'h1);
    tick();
    chk("rd_ack_c4", 32'(bus.cpu_ack), 32'h1);
    chk("rd_data_c4", 32'(bus.cpu_rdata), 32'h1234);
    chk("rd_dbg_rdata", 32'(bus.dbg_rdata), 32'h0);
    set_cpu(0, 0, 0, 0);
    tick();

    // Request dropped mid-transfer still completes with an ack.
    set_cpu(1, 0, 16'h0100, 16'h0);
    k_ack = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) set_cpu(0, 0, 0, 0);
      if (bus.cpu_ack && k_ack < 0) k_ack = k;
    end
    chk("drop_ack_cycle", 32'(k_ack), 32'd4);

    // Reset beats a simultaneous request; pointer returns to debug-last.
    set_cpu(1, 0, 16'h0074, 16'h0);
    Reset = 1'b1;
    tick(); chk("rst_prio_busy", 32'(bus.busy), 32'h0);
    Reset = 1'b0;
    set_cpu(0, 0, 0, 0);
    tick(); chk("rst_prio_idle", 32'(bus.busy), 32'h0);

    // Both requesting, two transfers each: CPU, debug, CPU, debug.
    set_cpu(1, 1, 16'h0100, 16'h1111);
    set_dbg(1, 0, 16'h0074, 16'h0);
    n_cpu = 0; n_dbg = 0; n_acks = 0; order = 0;
    for (int i = 0; i < 40 && (n_cpu < 2 || n_dbg < 2); i++) begin
      tick();
      if (bus.cpu_ack) begin
        order = order * 2; n_acks++; n_cpu++;
        if (n_cpu == 2) set_cpu(0, 0, 0, 0); else set_cpu(1, 0, 16'h0100, 16'h0);
      end
      if (bus.dbg_ack) begin
        order = order * 2 + 1; n_acks++; n_dbg++;
        if (n_dbg == 2) set_dbg(0, 0, 0, 0); else set_dbg(1, 1, 16'h0101, 16'h2222);
      end
    end
    chk("rr_acks", 32'(n_acks), 32'd4);
    chk("rr_order", 32'(order), 32'd5);
    tick();

    // Reset in the second ACCESS cycle of a debug write aborts it.
    set_dbg(1, 1, 16'h0075, 16'hBEEF);
    tick(); tick(); tick();
    Reset = 1'b1;
    set_dbg(0, 0, 0, 0);
    tick();
    chk("abort_we", 32'(bus.WE), 32'h1);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_ack", 32'(bus.dbg_ack), 32'h0);
    end

    // Debug read queued behind a CPU write starts in the IDLE cycle after DONE.
    set_cpu(1, 1, 16'h0074, 16'h5678);
    k_ack = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 2) set_dbg(1, 0, 16'h0075, 16'h0);
      if (bus.cpu_ack) set_cpu(0, 0, 0, 0);
      if (bus.dbg_ack) begin
        if (k_ack < 0) k_ack = k;
        set_dbg(0, 0, 0, 0);
      end
    end
    chk("queued_ack_cycle", 32'(k_ack), 32'd9);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
      end else begin
        Reset = 1'b0;
        if (!bus.cpu_req || bus.cpu_ack) begin
          if ($urandom_range(0, 2) != 0) set_cpu(1, 1'($urandom), rand_addr(), 16'($urandom));
          else set_cpu(0, 0, 0, 0);
        end
        if (!bus.dbg_req || bus.dbg_ack) begin
          if ($urandom_range(0, 2) != 0) set_dbg(1, 1'($urandom), rand_addr(), 16'($urandom));
          else set_dbg(0, 0, 0, 0);
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 2, giving the number of ACCESS cycles per SRAM transfer (legal range 1..15).
REQ-002 SHALL provide ports Clk  in  1  system clock (50 MHz), all state updates on rising edge.
REQ-003 SHALL provide port Reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL provide CPU port: cpu_req in 1, cpu_we in 1 (1=write), cpu_addr in 16, cpu_wdata in 16, cpu_rdata out 16, cpu_ack out 1.
REQ-005 SHALL provide debug/loader port: dbg_req in 1, dbg_we in 1, dbg_addr in 16, dbg_wdata in 16, dbg_rdata out 16, dbg_ack out 1.
REQ-006 SHALL provide SRAM port: CE, UB, LB, OE, WE out 1 each (active-low); ADDR out 20; Data inout 16 (tri-state).
REQ-007 SHALL provide status: busy out 1 (state != IDLE); grant out 1 (0=CPU, 1=debug; current/last owner).

Function
REQ-008 SHALL implement states IDLE, SETUP, ACCESS, DONE.
REQ-009 IDLE: if any req high, latch winner's we/addr/wdata, go SETUP; else stay IDLE.
REQ-010 Arbitration: single requester wins; both high -> requester not granted last wins (round-robin); pointer updates on IDLE->SETUP.
REQ-011 SETUP: 1 cycle; CE=0, UB=LB=0, ADDR={4'h0, latched addr}; OE=0 if read else 1; WE=1; Data hi-Z.
REQ-012 ACCESS: exactly WAIT_CYCLES cycles (internal counter); strobes as SETUP except write drives Data=latched wdata and WE=0.
REQ-013 Read data SHALL be captured from Data into the winner's rdata register on the edge leaving the last ACCESS cycle.
REQ-014 DONE: 1 cycle; CE=OE=WE=UB=LB=1, Data hi-Z; winner's ack=1 (single-cycle pulse), other ack=0; next state IDLE.
REQ-015 Latency: req first seen in IDLE cycle n -> ack high in cycle n+2+WAIT_CYCLES (n+4 at default).
REQ-016 Requester SHALL hold req and operands stable until ack; requester drops req on the edge ending the ack cycle; req still high in IDLE after DONE starts a new transfer.
REQ-017 Req dropped mid-transfer: transfer completes, ack still pulses.
REQ-018 Request arriving while busy SHALL wait; no request lost, none pre-empted.
REQ-019 Outside SETUP/ACCESS: CE=OE=WE=UB=LB=1, Data hi-Z, ADDR holds last value.
REQ-020 Data SHALL never be driven while OE=0; WE and OE never both 0.
REQ-021 rdata outputs hold last captured value until next read on that port; writes leave rdata unchanged.
REQ-022 Upper ADDR bits [19:16] SHALL always be 0.

Reset
REQ-023 Reset high at a rising edge -> next cycle state IDLE, counter 0, pointer = "debug last" (CPU wins first tie).
REQ-024 Reset values: cpu_rdata=dbg_rdata=16'h0000, cpu_ack=dbg_ack=0, busy=0, grant=0, ADDR=20'h0, CE=OE=WE=UB=LB=1, Data hi-Z.
REQ-025 Reset during SETUP/ACCESS/DONE SHALL abort the transfer: no ack, no rdata update, WE deasserted next cycle.
REQ-026 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-027 Reset 1 cycle, no reqs -> all strobes 1, Data Z, acks 0, rdata 0, busy 0 for 10 cycles.
REQ-028 CPU write 0x0074<-16'h1234 (req at cycle 0) -> ADDR=20'h00074 cycles 1-3, WE=0 and Data=1234 cycles 2-3, cpu_ack only cycle 4.
REQ-029 CPU read 0x0074, SRAM model holding 1234 -> OE=0 cycles 1-3, WE=1 throughout, cpu_rdata=16'h1234 at cycle 4 with cpu_ack, dbg_rdata unchanged.
REQ-030 cpu_req and dbg_req both high after reset, held for two transfers each -> grant order CPU, debug, CPU, debug; each ack single-cycle.
REQ-031 Reset pulsed in 2nd ACCESS cycle of debug write to 0x0075 -> WE=1 and busy=0 next cycle, dbg_ack never asserted.
REQ-032 dbg_req (read 0x0075) raised while CPU write busy -> debug transfer starts in IDLE after CPU DONE, dbg_ack 4 cycles after that IDLE cycle.
